// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and widths.
// Imported by the register file, ALU, muxes and control.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// Register file access bundle: two read ports, one write port.
// master = decode-stage driver, slave = register_file.
interface register_file_if;
  import mips_pkg::*;

  reg_addr_t read_reg1;
  reg_addr_t read_reg2;
  reg_addr_t write_reg;
  word_t     write_data;
  logic      reg_write;
  word_t     read_data1;
  word_t     read_data2;

  modport master (
    output read_reg1,
    output read_reg2,
    output write_reg,
    output write_data,
    output reg_write,
    input  read_data1,
    input  read_data2
  );

  modport slave (
    input  read_reg1,
    input  read_reg2,
    input  write_reg,
    input  write_data,
    input  reg_write,
    output read_data1,
    output read_data2
  );
endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: $zero detect, array select and,
// with REG_FILE_BYPASS_EN, write-through forwarding.
module register_file_read_port
  import mips_pkg::*;
(
  input  reg_addr_t addr_i,
  input  word_t     regs_i [NREGS],
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  word_t     wdata_i,
  output word_t     data_o
);

  logic is_zero;
  logic byp;

  assign is_zero = (addr_i == REG_ZERO);

`ifdef REG_FILE_BYPASS_EN
  assign byp = we_i && !is_zero &&
               (waddr_i == addr_i);
`else
  logic unused_byp;
  assign unused_byp = ^{we_i, waddr_i, wdata_i};
  assign byp = 1'b0;
`endif

  always_comb begin
    data_o = regs_i[addr_i];
    unique case (1'b1)
      is_zero: data_o = '0;
      byp:     data_o = wdata_i;
      default: data_o = regs_i[addr_i];
    endcase
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS register file, $zero hardwired, async active-low reset.
// Optional same-cycle forwarding when REG_FILE_BYPASS_EN is defined.
module register_file
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  register_file_if.slave rf
);

  word_t regs_q [NREGS];
  logic  wr_en;
  logic  byp_en;

  assign wr_en  = rf.reg_write &&
                  (rf.write_reg != REG_ZERO);
  // No forwarding while the array is held in reset
  assign byp_en = wr_en && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rf.write_reg] <= rf.write_data;
    end
  end

  register_file_read_port u_rp1 (
    .addr_i  (rf.read_reg1),
    .regs_i  (regs_q),
    .we_i    (byp_en),
    .waddr_i (rf.write_reg),
    .wdata_i (rf.write_data),
    .data_o  (rf.read_data1)
  );

  register_file_read_port u_rp2 (
    .addr_i  (rf.read_reg2),
    .regs_i  (regs_q),
    .we_i    (byp_en),
    .waddr_i (rf.write_reg),
    .wdata_i (rf.write_data),
    .data_o  (rf.read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed cases then random traffic.
// Build with the same REG_FILE_BYPASS_EN setting as the RTL.
module tb_register_file;
  import mips_pkg::*;

  typedef struct {
    string nm;
    word_t e1;
    word_t e2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  exp_t  sb[$];
  exp_t  mon_e;
  word_t model [NREGS];

  always #5 clk = ~clk;

  register_file_if rf ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );

  function automatic word_t exp_rd(reg_addr_t a);
    if (!rst_n || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (rf.reg_write && rf.write_reg == a)
      return rf.write_data;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
  endtask

  task automatic cyc(input reg_addr_t r1, input reg_addr_t r2,
                     input logic we, input reg_addr_t wa,
                     input word_t wd, input string nm);
    exp_t e;
    rf.read_reg1  = r1;
    rf.read_reg2  = r2;
    rf.reg_write  = we;
    rf.write_reg  = wa;
    rf.write_data = wd;
    e.nm = nm;
    e.e1 = exp_rd(r1);
    e.e2 = exp_rd(r2);
    sb.push_back(e);
    @(posedge clk);
    if (rst_n && we && wa != 0) model[wa] = wd;
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (rf.read_data1 !== mon_e.e1) begin
        errors++;
        $display("FAIL %s port1: got %h expected %h",
                 mon_e.nm, rf.read_data1, mon_e.e1);
      end
      checks++;
      if (rf.read_data2 !== mon_e.e2) begin
        errors++;
        $display("FAIL %s port2: got %h expected %h",
                 mon_e.nm, rf.read_data2, mon_e.e2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reg_addr_t wa, r1, r2;
    rst_n = 1'b0;
    rf.read_reg1 = '0;
    rf.read_reg2 = '0;
    rf.reg_write = 1'b0;
    rf.write_reg = '0;
    rf.write_data = '0;
    clear_model();
    @(posedge clk);
    #1;

    // 1. reset held for two cycles, write attempts ignored
    cyc(5'd1, 5'd2, 1'b1, 5'd1, 32'hCAFE_F00D, "rst_hold");
    cyc(5'd1, 5'd31, 1'b1, 5'd31, 32'h1111_2222, "rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i += 2)
      cyc(reg_addr_t'(i), reg_addr_t'(i + 1), 1'b0, 5'd0,
          32'h0, "rst_read");

    // 2. write/read
    cyc(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, "wr_r5");
    cyc(5'd0, 5'd0, 1'b1, 5'd9, 32'h0000_0042, "wr_r9");
    cyc(5'd5, 5'd9, 1'b0, 5'd0, 32'h0, "rd_r5_r9");
    cyc(5'd9, 5'd9, 1'b0, 5'd0, 32'h0, "same_addr");

    // 3. $zero protection
    cyc(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, "wr_zero");
    cyc(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, "rd_zero");

    // 4. write disabled
    cyc(5'd5, 5'd0, 1'b0, 5'd5, 32'h0000_1234, "we_off");
    cyc(5'd5, 5'd9, 1'b0, 5'd0, 32'h0, "rd_we_off");

    // 5. async reset between edges, pending write lost
    cyc(5'd0, 5'd0, 1'b1, 5'd7, 32'hA5A5_A5A5, "wr_r7");
    cyc(5'd7, 5'd5, 1'b0, 5'd0, 32'h0, "rd_r7");
    rst_n = 1'b0;
    clear_model();
    cyc(5'd7, 5'd5, 1'b1, 5'd7, 32'h0BAD_0BAD, "rst_mid");
    rst_n = 1'b1;
    cyc(5'd7, 5'd9, 1'b1, 5'd7, 32'h0000_0077, "wr_after_rst");
    cyc(5'd7, 5'd5, 1'b0, 5'd0, 32'h0, "rd_after_rst");

    // 6. same-cycle read/write
    cyc(5'd0, 5'd0, 1'b1, 5'd3, 32'h0000_0010, "wr_r3");
    cyc(5'd3, 5'd4, 1'b1, 5'd3, 32'h0000_0020, "same_cycle");
    cyc(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, "after_edge");

    // random traffic, biased toward read-after-write hazards
    for (int n = 0; n < 400; n++) begin
      wa = reg_addr_t'($urandom_range(0, NREGS - 1));
      r1 = ($urandom_range(0, 3) == 0) ? wa :
           reg_addr_t'($urandom_range(0, NREGS - 1));
      r2 = ($urandom_range(0, 3) == 0) ? wa :
           reg_addr_t'($urandom_range(0, NREGS - 1));
      cyc(r1, r2, 1'($urandom_range(0, 1)), wa, $urandom, "rand");
    end

    rf.reg_write = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
